// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one 8051 ALU instruction at a time (read Rn, issue, write back).
// Optional SEQ_BACK_TO_BACK_EN: accept the next instruction during write-back for 3-cycle throughput.
module alu_sequencer #(
  parameter logic [7:0] NOP_OPCODE = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [7:0] instr_opcode,
  input  logic [7:0] instr_imm,
  output logic [2:0] rf_raddr,
  input  logic [7:0] rf_rdata,
  output logic       rf_we,
  output logic [2:0] rf_waddr,
  output logic [7:0] rf_wdata,
  output logic [7:0] alu_opcode,
  output logic [7:0] alu_operand1,
  output logic [7:0] alu_operand2,
  input  logic [8:0] alu_result,
  input  logic       alu_psw_c,
  output logic [7:0] acc,
  output logic       psw_c,
  output logic       done,
  output logic       illegal_op
);

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    ISSUE = 2'd2,
    WB    = 2'd3
  } state_t;

  typedef struct packed {
    logic legal;
    logic imm_src;
    logic dst_rn;
    logic upd_c;
  } dec_t;

  function automatic dec_t decode(input logic [7:0] op);
    dec_t d;
    d = '0;
    casez (op)
      8'h74:        begin d.legal = 1'b1; d.imm_src = 1'b1; end
      8'b1110_1???: d.legal = 1'b1;
      8'b0111_1???: begin d.legal = 1'b1; d.imm_src = 1'b1; d.dst_rn = 1'b1; end
      8'b0010_1???: begin d.legal = 1'b1; d.upd_c = 1'b1; end
      8'b1001_1???: begin d.legal = 1'b1; d.upd_c = 1'b1; end
      8'b0101_1???: d.legal = 1'b1;
      8'b0100_1???: d.legal = 1'b1;
      8'b0110_1???: d.legal = 1'b1;
      default:      d = '0;
    endcase
    return d;
  endfunction

  state_t state, state_nxt;

  logic [7:0]        opcode_p0;
  logic [DATA_W-1:0] imm_p0;
  logic [DATA_W-1:0] rn_p1;
  dec_t              dec_in;
  dec_t              dec_p0;
  logic              accept;
  logic              illegal_nxt;
  logic              unused_alu_bit8;

  // The ALU flag output is the carry source; bit 8 of the result bus duplicates it.
  assign unused_alu_bit8 = alu_result[8];

  assign dec_in = decode(instr_opcode);
  assign dec_p0 = decode(opcode_p0);
  assign accept = instr_valid & instr_ready;

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    illegal_nxt = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (accept) begin
          if (dec_in.legal) state_nxt = READ;
          else              illegal_nxt = 1'b1;
        end
      end
      READ:  state_nxt = ISSUE;
      ISSUE: state_nxt = WB;
      WB: begin
        state_nxt = IDLE;
`ifdef SEQ_BACK_TO_BACK_EN
        instr_ready = 1'b1;
        if (accept) begin
          if (dec_in.legal) state_nxt = READ;
          else              illegal_nxt = 1'b1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rf_raddr     = '0;
    alu_opcode   = NOP_OPCODE;
    alu_operand1 = acc;
    alu_operand2 = '0;
    rf_we        = 1'b0;
    rf_waddr     = '0;
    rf_wdata     = '0;
    if (state == READ) begin
      rf_raddr = opcode_p0[2:0];
    end
    if (state == ISSUE) begin
      alu_opcode   = opcode_p0;
      alu_operand2 = dec_p0.imm_src ? imm_p0 : rn_p1;
    end
    // Rn write is combinational in WB so a following READ sees it right after the edge.
    if (state == WB && dec_p0.dst_rn) begin
      rf_we    = 1'b1;
      rf_waddr = opcode_p0[2:0];
      rf_wdata = alu_result[7:0];
    end
  end

  // ---- control / architectural state: accumulator, carry, status pulses ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      acc        <= '0;
      psw_c      <= 1'b0;
      done       <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      state      <= state_nxt;
      done       <= (state == WB);
      illegal_op <= illegal_nxt;
      if (state == WB) begin
        if (!dec_p0.dst_rn) acc   <= alu_result[7:0];
        if (dec_p0.upd_c)   psw_c <= alu_psw_c;
      end
    end
  end

  // ---- p0: instruction latch on accept; p1: Rn operand latch in READ ----
  always_ff @(posedge clock) begin
    if (accept) begin
      opcode_p0 <= instr_opcode;
      imm_p0    <= instr_imm;
    end
    if (state == READ) begin
      rn_p1 <= rf_rdata;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench with register-file and registered-ALU models around alu_sequencer.
`timescale 1ns/1ps
module tb_alu_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [7:0] instr_opcode = 8'h00;
  logic [7:0] instr_imm = 8'h00;
  logic [2:0] rf_raddr;
  logic [7:0] rf_rdata;
  logic       rf_we;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic [7:0] alu_opcode;
  logic [7:0] alu_operand1;
  logic [7:0] alu_operand2;
  logic [8:0] alu_result;
  logic       alu_psw_c;
  logic [7:0] acc;
  logic       psw_c;
  logic       done;
  logic       illegal_op;

  always #5 clock = ~clock;

  alu_sequencer #(.NOP_OPCODE(8'h00)) dut (
    .clock(clock), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_imm(instr_imm),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_opcode(alu_opcode), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_result(alu_result), .alu_psw_c(alu_psw_c),
    .acc(acc), .psw_c(psw_c), .done(done), .illegal_op(illegal_op)
  );

`ifdef SEQ_BACK_TO_BACK_EN
  localparam int DONE_GAP = 3;
`else
  localparam int DONE_GAP = 4;
`endif

  // Register file: combinational read, write on rising edge.
  logic [7:0] rf [8];
  assign rf_rdata = rf[rf_raddr];
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
    end else if (rf_we) begin
      rf[rf_waddr] <= rf_wdata;
    end
  end

  // Registered ALU; NOP and unknown opcodes hold the previous result.
  always @(posedge clock or negedge reset) begin
    if (!reset) alu_result <= 9'h000;
    else begin
      casez (alu_opcode)
        8'h74, 8'b0111_1???, 8'b1110_1???: alu_result <= {1'b0, alu_operand2};
        8'b0010_1???: alu_result <= {1'b0, alu_operand1} + {1'b0, alu_operand2};
        8'b1001_1???: alu_result <= {1'b0, alu_operand1} - {1'b0, alu_operand2};
        8'b0101_1???: alu_result <= {1'b0, alu_operand1 & alu_operand2};
        8'b0100_1???: alu_result <= {1'b0, alu_operand1 | alu_operand2};
        8'b0110_1???: alu_result <= {1'b0, alu_operand1 ^ alu_operand2};
        default: ;
      endcase
    end
  end
  assign alu_psw_c = alu_result[8];

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic       legal;
    logic       wr;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic [7:0] acc;
    logic       c;
    int         acc_cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] acc_m = 8'h00;
  logic       psw_m = 1'b0;
  logic [7:0] rf_m [8];

  // Instruction-level reference model of architectural effects.
  task automatic predict(input logic [7:0] op, input logic [7:0] imm, output exp_t e);
    logic [8:0] r;
    logic [7:0] rn;
    rn = rf_m[op[2:0]];
    e.legal = 1'b1; e.wr = 1'b0; e.waddr = 3'd0; e.wdata = 8'h00; e.acc_cyc = 0;
    if (op == 8'h74) acc_m = imm;
    else if (op[7:3] == 5'b11101) acc_m = rn;
    else if (op[7:3] == 5'b01111) begin
      rf_m[op[2:0]] = imm; e.wr = 1'b1; e.waddr = op[2:0]; e.wdata = imm;
    end
    else if (op[7:3] == 5'b00101) begin r = {1'b0, acc_m} + {1'b0, rn}; acc_m = r[7:0]; psw_m = r[8]; end
    else if (op[7:3] == 5'b10011) begin r = {1'b0, acc_m} - {1'b0, rn}; acc_m = r[7:0]; psw_m = r[8]; end
    else if (op[7:3] == 5'b01011) acc_m = acc_m & rn;
    else if (op[7:3] == 5'b01001) acc_m = acc_m | rn;
    else if (op[7:3] == 5'b01101) acc_m = acc_m ^ rn;
    else e.legal = 1'b0;
    e.acc = acc_m;
    e.c   = psw_m;
  endtask

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int         wr_seen = 0;
  logic [2:0] wr_addr = 3'd0;
  logic [7:0] wr_data = 8'h00;
  int         last_done = -1;
  logic       stream_mode = 1'b0;
  exp_t       mon_e;

  // Output monitor: pops one scoreboard entry per done / illegal_op pulse.
  always @(negedge clock) begin
    if (reset) begin
      if (rf_we) begin
        wr_seen++;
        wr_addr = rf_waddr;
        wr_data = rf_wdata;
      end
      if (done || illegal_op) begin
        if (sb.size() == 0) begin
          check_val("unexpected_output", {30'd0, done, illegal_op}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check_val("pulse_kind", {30'd0, done, illegal_op}, mon_e.legal ? 32'd2 : 32'd1);
          check_val("latency", cyc - mon_e.acc_cyc, mon_e.legal ? 32'd3 : 32'd0);
          check_val("acc", {24'd0, acc}, {24'd0, mon_e.acc});
          check_val("psw_c", {31'd0, psw_c}, {31'd0, mon_e.c});
          check_val("rf_we_count", wr_seen, {31'd0, mon_e.wr});
          if (mon_e.wr) begin
            check_val("rf_waddr", {29'd0, wr_addr}, {29'd0, mon_e.waddr});
            check_val("rf_wdata", {24'd0, wr_data}, {24'd0, mon_e.wdata});
          end
          if (done && stream_mode && last_done >= 0)
            check_val("done_gap", cyc - last_done, DONE_GAP);
        end
        wr_seen = 0;
        if (done) last_done = cyc;
      end
    end
  end

  task automatic issue(input logic [7:0] op, input logic [7:0] imm);
    exp_t e;
    int   n;
    predict(op, imm, e);
    instr_opcode = op;
    instr_imm    = imm;
    instr_valid  = 1'b1;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!instr_ready) begin
      check_val("accept_timeout", 32'd0, 32'd1);
      instr_valid = 1'b0;
      return;
    end
    e.acc_cyc = cyc + 1;
    sb.push_back(e);
    @(posedge clock);
    #1 instr_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      check_val("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_ready"},    {31'd0, instr_ready}, 32'd1);
    check_val({pfx, "_done"},     {31'd0, done}, 32'd0);
    check_val({pfx, "_illegal"},  {31'd0, illegal_op}, 32'd0);
    check_val({pfx, "_rf_we"},    {31'd0, rf_we}, 32'd0);
    check_val({pfx, "_rf_waddr"}, {29'd0, rf_waddr}, 32'd0);
    check_val({pfx, "_rf_wdata"}, {24'd0, rf_wdata}, 32'd0);
    check_val({pfx, "_rf_raddr"}, {29'd0, rf_raddr}, 32'd0);
    check_val({pfx, "_alu_op"},   {24'd0, alu_opcode}, 32'h00);
    check_val({pfx, "_alu_op1"},  {24'd0, alu_operand1}, 32'd0);
    check_val({pfx, "_alu_op2"},  {24'd0, alu_operand2}, 32'd0);
    check_val({pfx, "_acc"},      {24'd0, acc}, 32'd0);
    check_val({pfx, "_psw_c"},    {31'd0, psw_c}, 32'd0);
  endtask

  logic [7:0] stream_ops [8] = '{8'h74, 8'h2A, 8'h9B, 8'h5E, 8'h4B, 8'h6A, 8'h7A, 8'hEA};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) rf_m[i] = 8'h00;
    #1 check_reset_outputs("reset");
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    issue(8'h74, 8'h5A);
    drain();

    issue(8'h7B, 8'hC0);
    issue(8'h74, 8'h50);
    issue(8'h2B, 8'h00);
    issue(8'h5B, 8'h00);
    drain();

    issue(8'h79, 8'h07);
    issue(8'h74, 8'h05);
    issue(8'h99, 8'h00);
    drain();

    issue(8'h7E, 8'h33);
    issue(8'hA5, 8'h00);
    issue(8'hE9, 8'h00);
    issue(8'h4B, 8'h00);
    issue(8'h6E, 8'h00);
    issue(8'h29, 8'h00);
    drain();

    stream_mode = 1'b1;
    last_done   = -1;
    for (int i = 0; i < 8; i++) issue(stream_ops[i], 8'($urandom_range(0, 255)));
    drain();
    stream_mode = 1'b0;

    // Reset while an ADD sits in ISSUE: no write-back may follow.
    issue(8'h2B, 8'h00);
    @(posedge clock);
    #1 check_val("issue_alu_opcode", {24'd0, alu_opcode}, 32'h2B);
    reset = 1'b0;
    sb.delete();
    acc_m = 8'h00;
    psw_m = 1'b0;
    for (int i = 0; i < 8; i++) rf_m[i] = 8'h00;
    #1 check_reset_outputs("midreset");
    repeat (2) @(negedge clock);
    wr_seen = 0;
    reset = 1'b1;
    repeat (6) @(negedge clock);
    check_val("post_reset_acc", {24'd0, acc}, 32'd0);

    issue(8'h74, 8'h3C);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
